// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter between clients
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int GAP_CYCLES    = 2,
   parameter int START_TIMEOUT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   input  logic                          tx_busy,
   output logic                          tx_data_valid,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic [$clog2(NUM_REQ)-1:0]    active_id,
   output logic                          arb_busy,
   output logic                          timeout_err
);

   localparam int IDW     = $clog2(NUM_REQ);
   localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // Last count value of the start watchdog and of the inter-frame gap
   localparam logic [CW-1:0]  TO_LAST   = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0]  GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   // Pointer starts at the last client so client 0 wins the first contest
   localparam logic [IDW-1:0] PTR_RESET = IDW'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      ARB,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } state_t;

   state_t                state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0]    gnt_q, gnt_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDW-1:0]        id_q, id_d;
   logic                  arb_busy_q, arb_busy_d;
   logic                  timeout_q, timeout_d;

   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
   logic                  win_found;
   logic [IDW-1:0]        win_id;
   logic [IDW-1:0]        cand;

   // Split the packed client bus into one byte per client
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Rotating-priority search starting just after the previous winner
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int o = 1; o <= NUM_REQ; o++) begin
         cand = IDW'((int'(ptr_q) + o) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Next-state and registered-output values for the scheduling FSM
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      done_d    = '0;
      valid_d   = 1'b0;
      data_d    = data_q;
      id_d      = id_q;
      timeout_d = 1'b0;

      case (state_q)
         ARB: begin
            // A busy transmitter (e.g. frame left over from a reset) blocks any grant
            if (win_found && !tx_busy) begin
               gnt_d[win_id] = 1'b1;
               data_d        = req_bytes[win_id];
               id_d          = win_id;
               ptr_d         = win_id;
               state_d       = ISSUE;
            end
         end

         ISSUE: begin
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end

         WAIT_BUSY: begin
            // Busy rising wins over the watchdog on the last allowed cycle
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = (GAP_CYCLES > 0) ? GAP : ARB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         WAIT_DONE: begin
            if (!tx_busy) begin
               done_d[id_q] = 1'b1;
               cnt_d        = '0;
               state_d      = (GAP_CYCLES > 0) ? GAP : ARB;
            end
         end

         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ARB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ARB;
         end
      endcase

      arb_busy_d = (state_d != ARB);
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         ptr_q      <= PTR_RESET;
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         id_q       <= '0;
         arb_busy_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         id_q       <= id_d;
         arb_busy_q <= arb_busy_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt           = gnt_q;
   assign done          = done_q;
   assign tx_data_valid = valid_q;
   assign tx_p_data     = data_q;
   assign active_id     = id_q;
   assign arb_busy      = arb_busy_q;
   assign timeout_err   = timeout_q;

endmodule
